ssd_scan_ctrl: RTL
==================

# ssd_scan_ctrl

Time-multiplexed scan controller for the board's four-digit common-anode seven-segment display. It latches a 16-bit hex value, a decimal-point mask and a digit-enable mask into shadow registers at frame boundaries. It then cycles through the four digits, driving the shared active-low segment bus and one active-low anode at a time, with a blanking gap before each digit to suppress ghosting. It sits between the keyboard/VGA logic that produces values and the board's `ssd`/`an` pins.

## Interface
- `REFRESH_DIV`, 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz); must be ≥ 2.
- `BLANK_CYC`, 1000: cycles at the start of each slot with all anodes off; 0 ≤ `BLANK_CYC` < `REFRESH_DIV`.
- `clk`  in  1  system clock; the block uses one clock, all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `value`  in  16  hex digits; digit i = `value[4i+3:4i]`.
- `dp`  in  4  decimal point per digit, 1 = lit.
- `digit_en`  in  4  digit enable, 1 = digit shown.
- `load`  in  1  single-cycle request to capture `value`/`dp`/`digit_en`.
- `ssd`  out  8  segments, active-low, bit0 = A … bit6 = G, bit7 = DP.
- `an`  out  4  anodes, active-low, `an[i]` selects digit i.
- `frame_done`  out  1  one-cycle pulse at the end of each four-slot frame.

## Operation
- State: slot counter `cnt` (0..`REFRESH_DIV`-1), digit index `dig` (0..3, wraps 3→0), phase FSM {BLANK, SHOW}, a pending-load flag, and shadow registers `sh_value`/`sh_dp`/`sh_en`.
- Phase: BLANK while `cnt` < `BLANK_CYC`, SHOW otherwise. When `cnt` = `REFRESH_DIV`-1, `cnt`→0 and `dig` increments.
- BLANK: `an`=4'hF, `ssd`=8'hFF.
- SHOW with `sh_en[dig]`=1: `an` = all ones except bit `dig` = 0. `ssd` = ~(hex pattern of `sh_value` nibble, with bit7 = `sh_dp[dig]`).
- SHOW with `sh_en[dig]`=0: same outputs as BLANK. The slot is still consumed, so brightness stays uniform.
- Hex patterns (active-high A..G, before inversion): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- `load`=1 sets the pending flag and captures the inputs into a staging register. If several loads arrive before a boundary, the last one wins.
- Frame boundary: the cycle with `dig`=3 and `cnt`=`REFRESH_DIV`-1.
  - At that edge, pending staging data is copied to the shadow registers and pending clears.
  - A `load` asserted in the boundary cycle itself is applied at that edge.
- `frame_done` is high during the frame-boundary cycle only.
- When `BLANK_CYC`=0, there is no blank phase; adjacent digits switch anodes edge-to-edge.

## Timing
- Reset values (immediate, asynchronous): `an`=4'hF, `ssd`=8'hFF, `frame_done`=0, `cnt`=0, `dig`=0, phase BLANK, pending=0, all shadow and staging registers = 0. The display therefore stays dark until the first load is applied.
- `ssd`, `an` and `frame_done` are registered with no combinational path from inputs.
- Cycle 0 is the first rising edge after `rst` falls. From that edge, outputs reflect the computed `cnt`/`dig` with 1-cycle output latency. Digit k is lit for cycles [k·R + B + 1, (k+1)·R] (R = `REFRESH_DIV`, B = `BLANK_CYC`), relative to cycle 0.
- Load-to-display latency: at most 4·R + B + 1 cycles, at least B + 1 cycles after the boundary edge.
- Reset asserted mid-frame aborts the frame. Outputs are dark and pending loads are discarded, and the scan restarts from digit 0.
- At most one anode is low in any cycle, guaranteed including at slot transitions.

## Structure
- Package `ssd_pkg`:
  - constants `SEG_A`..`SEG_G` = 0..6 and `SEG_DP` = 7
  - `SSD_OFF` = 8'hFF, `AN_OFF` = 4'hF
  - phase enum {BLANK, SHOW}
- Sub-module `hex_to_seg`: combinational 4-bit → 7-bit active-high A..G decoder, instantiated once on the muxed nibble.
- Parameter legality is checked at elaboration. An illegal `BLANK_CYC`/`REFRESH_DIV` combination is a fatal error.

## Test plan
All scenarios use `REFRESH_DIV`=8, `BLANK_CYC`=2.
- Reset check: `rst` high, then released with no load → `an`=F, `ssd`=FF every cycle. `frame_done` pulses every 32 cycles, first at cycle 31.
- Digit scan: load `value`=16'h3210, `dp`=0, `digit_en`=F before the first boundary. In the next frame, digit 0 shows `an`=E, `ssd`=C0; digit 1 shows `an`=D, `ssd`=F9; each digit lights for 6 cycles after 2 dark cycles.
- Decimal points and disabled digits: `value`=16'h8A8F, `dp`=4'b0010, `digit_en`=4'b1011 → digit 0 shows `ssd`=8E. Digit 1 shows `ssd`=00 (8 with DP lit). Digit 2's slot stays dark for 8 cycles. Digit 3 shows `ssd`=80.
- Load timing: loads of 16'h1111 then 16'h2222 mid-frame → the display keeps the old value until the boundary, then shows 2222 only. A load asserted in the boundary cycle appears in the immediately following frame.
- Reset mid-frame: assert `rst` during digit 2 SHOW → `an`=F and `ssd`=FF asynchronously. After release, scanning restarts at digit 0 with the display dark.
- Anode exclusivity: random loads over 10,000 cycles → the assertion that `an` has at most one zero bit never fires.

Source files
------------

// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared constants and phase type for the seven-segment scan controller
package ssd_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] SSD_OFF = 8'hFF;
    localparam logic [3:0] AN_OFF  = 4'hF;

    typedef enum logic {
        BLANK,
        SHOW
    } phase_e;

endpackage

// File: rtl/hex_to_seg.sv
// rtl/hex_to_seg.sv - hex nibble to active-high A..G segment decoder
module hex_to_seg (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'h00;
        case (hex_i)
            4'h0: seg_o = 7'h3F;
            4'h1: seg_o = 7'h06;
            4'h2: seg_o = 7'h5B;
            4'h3: seg_o = 7'h4F;
            4'h4: seg_o = 7'h66;
            4'h5: seg_o = 7'h6D;
            4'h6: seg_o = 7'h7D;
            4'h7: seg_o = 7'h07;
            4'h8: seg_o = 7'h7F;
            4'h9: seg_o = 7'h6F;
            4'hA: seg_o = 7'h77;
            4'hB: seg_o = 7'h7C;
            4'hC: seg_o = 7'h39;
            4'hD: seg_o = 7'h5E;
            4'hE: seg_o = 7'h79;
            4'hF: seg_o = 7'h71;
            default: seg_o = 7'h00;
        endcase
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// rtl/ssd_scan_ctrl.sv - four-digit multiplexed seven-segment scanner with frame-aligned shadow loads
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 1000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] value_i,
    input  logic [3:0]  dp_i,
    input  logic [3:0]  digit_en_i,
    input  logic        load_i,
    output logic [7:0]  ssd_o,
    output logic [3:0]  an_o,
    output logic        frame_done_o
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

    generate
        if (REFRESH_DIV < 2 || BLANK_CYC < 0 || BLANK_CYC >= REFRESH_DIV) begin : g_bad_params
            $fatal(1, "ssd_scan_ctrl: illegal REFRESH_DIV/BLANK_CYC combination");
        end
    endgenerate

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dig_q, dig_d;
    phase_e        phase_q, phase_d;
    logic          pend_q, pend_d;
    logic [15:0]   stg_value_q, stg_value_d, sh_value_q, sh_value_d;
    logic [3:0]    stg_dp_q, stg_dp_d, sh_dp_q, sh_dp_d;
    logic [3:0]    stg_en_q, stg_en_d, sh_en_q, sh_en_d;
    logic [7:0]    ssd_q, ssd_d;
    logic [3:0]    an_q, an_d;
    logic          fd_q, fd_d;

    logic          last_slot;
    logic          boundary;
    logic          lit;
    logic [3:0]    nibble;
    logic [6:0]    seg;

    hex_to_seg u_hex_to_seg (
        .hex_i (nibble),
        .seg_o (seg)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            dig_q       <= 2'd0;
            phase_q     <= BLANK;
            pend_q      <= 1'b0;
            stg_value_q <= 16'h0000;
            stg_dp_q    <= 4'h0;
            stg_en_q    <= 4'h0;
            sh_value_q  <= 16'h0000;
            sh_dp_q     <= 4'h0;
            sh_en_q     <= 4'h0;
            ssd_q       <= SSD_OFF;
            an_q        <= AN_OFF;
            fd_q        <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            dig_q       <= dig_d;
            phase_q     <= phase_d;
            pend_q      <= pend_d;
            stg_value_q <= stg_value_d;
            stg_dp_q    <= stg_dp_d;
            stg_en_q    <= stg_en_d;
            sh_value_q  <= sh_value_d;
            sh_dp_q     <= sh_dp_d;
            sh_en_q     <= sh_en_d;
            ssd_q       <= ssd_d;
            an_q        <= an_d;
            fd_q        <= fd_d;
        end
    end

    always_comb begin
        last_slot = (cnt_q == CNT_LAST);
        boundary  = last_slot && (dig_q == 2'd3);

        cnt_d   = last_slot ? '0 : cnt_q + CW'(1);
        dig_d   = last_slot ? dig_q + 2'd1 : dig_q;
        phase_d = (cnt_d < BLANK_END) ? BLANK : SHOW;

        stg_value_d = load_i ? value_i    : stg_value_q;
        stg_dp_d    = load_i ? dp_i       : stg_dp_q;
        stg_en_d    = load_i ? digit_en_i : stg_en_q;
        pend_d      = boundary ? 1'b0 : (pend_q | load_i);

        sh_value_d = sh_value_q;
        sh_dp_d    = sh_dp_q;
        sh_en_d    = sh_en_q;
        // A load in the boundary cycle bypasses staging so it is not lost for a frame.
        if (boundary && load_i) begin
            sh_value_d = value_i;
            sh_dp_d    = dp_i;
            sh_en_d    = digit_en_i;
        end else if (boundary && pend_q) begin
            sh_value_d = stg_value_q;
            sh_dp_d    = stg_dp_q;
            sh_en_d    = stg_en_q;
        end

        nibble = sh_value_q[{dig_q, 2'b00} +: 4];
        lit    = (phase_q == SHOW) && sh_en_q[dig_q];
        an_d   = lit ? ~(4'b0001 << dig_q) : AN_OFF;
        ssd_d  = SSD_OFF;
        if (lit) begin
            ssd_d         = ~{1'b0, seg};
            ssd_d[SEG_DP] = ~sh_dp_q[dig_q];
        end

        // Look ahead one cycle so the registered pulse lines up with the boundary cycle.
        fd_d = (cnt_d == CNT_LAST) && (dig_d == 2'd3);
    end

    assign ssd_o        = ssd_q;
    assign an_o         = an_q;
    assign frame_done_o = fd_q;

endmodule
